reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Next-generation multi-ported register file for the superscalar MIPS core, sitting between decode/issue and writeback.
- Generalises width, depth, read-port count and write-port count.
- Adds a same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: issue sets a bit, writeback clears it. Decode uses the bit for RAW hazard stalls.

Parameters:
DW, 32, data width per register
NREG, 32, number of architectural registers (power of two, >=2)
AW, 5, address width, must equal log2(NREG)
NR, 4, number of read ports
NW, 2, number of write (writeback) ports
NI, 2, number of issue ports (scoreboard set ports)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
raddr  in  NR*AW  read addresses, port k at [k*AW +: AW]
rdata  out  NR*DW  read data, port k at [k*DW +: DW], combinational
rbusy  out  NR  scoreboard busy flag for raddr port k, combinational
we  in  NW  write enables
waddr  in  NW*AW  write addresses
wdata  in  NW*DW  write data
iss_valid  in  NI  issue strobe; marks iss_addr busy
iss_addr  in  NI*AW  destination register of issued instruction

Behaviour:
- Reset is synchronous and active-high: on posedge clk with reset=1, all NREG registers go to 0 and all busy bits clear.
  - Reset dominates any we/iss_valid in the same cycle.
  - After reset: rdata=0 and rbusy=0 for every port.
- Register 0 is hardwired zero.
  - Writes to address 0 are dropped.
  - Issues to address 0 never set busy.
  - Reads of address 0 return 0 with rbusy=0, regardless of bypass.
- Write: on posedge, for each j with we[j]=1 and waddr[j]!=0, mem[waddr[j]] <= wdata[j].
  - Multiple ports writing the same address: highest index j wins; lower ports are suppressed for that address.
- Read (combinational, zero latency):
  - rdata[k] = wdata of the highest-index j with we[j] & waddr[j]==raddr[k] & raddr[k]!=0.
  - Otherwise mem[raddr[k]].
  - The bypass makes a same-cycle writeback visible to decode without a half-cycle write.
- Scoreboard, next-state per register r != 0:
  - busy[r] set if any iss_valid[i] with iss_addr[i]==r.
  - Otherwise cleared if any we[j] with waddr[j]==r.
  - Otherwise held.
  - Simultaneous issue and writeback to the same r: set wins, because the newer producer is outstanding.
  - Duplicate issues to the same r in one cycle: single set, no error.
- rbusy[k] = busy[raddr[k]] & ~(any we[j] with waddr[j]==raddr[k]).
  - A writeback in the current cycle un-busies the read, consistent with the bypassed rdata.
  - Same-cycle issue is not visible until the next cycle.
- Writeback to a non-busy register is legal: the write is performed and busy stays 0.
- No other state, no stalls, no handshake back-pressure.
- All counts are parameter-driven; no hard-coded port numbers in logic.

Decomposition:
- Shared package `rf_pkg`:
  - ZERO_REG=0
  - default DW/NREG/AW
  - helper function for highest-index match over NW ports
- One sub-module, `rf_bypass_mux`, instantiated NR times.
  - Inputs: one raddr, all we/waddr/wdata, the array word.
  - Outputs: rdata and the wb-hit flag used for rbusy.
- Top level holds the storage array, the write-priority logic and the scoreboard.

Test Plan:
1. Reset with we=2'b11, waddr={5,5}, iss to 7 asserted -> next cycle all rdata=0, rbusy=0; mem[5]=0, busy[7]=0.
2. Write port0 r3=0xDEADBEEF; port1 idle -> same cycle raddr0=3 reads 0xDEADBEEF via bypass; next cycle it reads from array with we=0.
3. Both ports write r9: port0=0x11, port1=0x22 -> same-cycle read 0x22; next cycle mem[9]=0x22.
4. Write to r0 value 0xFFFFFFFF, issue to r0 -> rdata for raddr=0 is 0 both cycles; rbusy=0.
5. Issue r4 in cycle t -> rbusy for r4 is 0 at t and 1 at t+1. Writeback r4 at t+3 -> rbusy=0 at t+3 (bypass) with rdata=wdata, busy[4]=0 at t+4.
6. Same cycle: issue r6 on iss1 and writeback r6 on we0, with busy[6]=1 beforehand -> busy[6]=1 next cycle; the current-cycle read sees rbusy=0 and rdata=wdata.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : rf_pkg                                                           |
// | Shared constants and priority helper for the multi-ported register file.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package rf_pkg;

  localparam int ZERO_REG  = 0;
  localparam int DEF_DW    = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_AW    = 5;
  localparam int MAX_PORTS = 32;

  // Highest set index of a hit vector; callers qualify the result with |hits.
  function automatic int hi_idx(input logic [MAX_PORTS-1:0] hits);
    int idx;
    idx = 0;
    for (int j = 0; j < MAX_PORTS; j++) begin
      if (hits[j]) idx = j;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : reg_file_mp_if                                                 |
// | Read, writeback and issue buses of the multi-ported register file.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface reg_file_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 4,
  parameter int NW = 2,
  parameter int NI = 2
);
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NI-1:0]    iss_valid;
  logic [NI*AW-1:0] iss_addr;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_addr,
    output rdata, rbusy
  );
endinterface
`default_nettype wire

// File: rtl/rf_bypass_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rf_bypass_mux                                                     |
// | One read port: array word or same-cycle writeback data, r0 forced to 0.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NW = 2
) (
  input  logic [AW-1:0]    raddr,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [DW-1:0]    array_word,
  output logic [DW-1:0]    rdata,
  output logic             wb_hit
);

  logic [NW-1:0] hits;
  logic          nonzero;
  int            sel;

  always_comb begin
    hits = '0;
    for (int j = 0; j < NW; j++) begin
      hits[j] = we[j] && (waddr[j*AW +: AW] == raddr);
    end
    nonzero = (raddr != AW'(ZERO_REG));
    sel     = hi_idx(MAX_PORTS'(hits));
    wb_hit  = nonzero && (|hits);
    rdata   = '0;
    if (wb_hit) begin
      rdata = wdata[sel*DW +: DW];
    end else if (nonzero) begin
      rdata = array_word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : reg_file_mp                                                       |
// | Multi-ported register file with writeback bypass and busy scoreboard.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int NR   = 4,
  parameter int NW   = 2,
  parameter int NI   = 2
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [DW-1:0]   rd_word [NR];
  logic [NR-1:0]   rd_hit;
  logic [NR-1:0]   rd_busy;

  // Ascending port order lets the highest-index writer win on collisions.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j] && (bus.waddr[j*AW +: AW] != AW'(ZERO_REG))) begin
        mem_d[bus.waddr[j*AW +: AW]] = bus.wdata[j*DW +: DW];
      end
    end
  end

  // Clears are applied first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.we[j]) busy_d[bus.waddr[j*AW +: AW]] = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      if (bus.iss_valid[i]) busy_d[bus.iss_addr[i*AW +: AW]] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_read
    rf_bypass_mux #(
      .DW (DW),
      .AW (AW),
      .NW (NW)
    ) u_mux (
      .raddr      (bus.raddr[k*AW +: AW]),
      .we         (bus.we),
      .waddr      (bus.waddr),
      .wdata      (bus.wdata),
      .array_word (mem_q[bus.raddr[k*AW +: AW]]),
      .rdata      (rd_word[k]),
      .wb_hit     (rd_hit[k])
    );
  end

  always_comb begin
    rd_busy   = '0;
    bus.rdata = '0;
    for (int k = 0; k < NR; k++) begin
      rd_busy[k]             = busy_q[bus.raddr[k*AW +: AW]] & ~rd_hit[k];
      bus.rdata[k*DW +: DW]  = rd_word[k];
    end
    bus.rbusy = rd_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Testbench : tb_reg_file_mp                                                 |
// | Directed vectors with hand-computed expectations for reg_file_mp.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NI = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  reg_file_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .NI(NI)) bus ();

  reg_file_mp #(
    .DW(DW), .NREG(32), .AW(AW), .NR(NR), .NW(NW), .NI(NI)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we        = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.iss_valid = '0;
    bus.iss_addr  = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    bus.raddr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[j]             = 1'b1;
    bus.waddr[j*AW +: AW] = a;
    bus.wdata[j*DW +: DW] = d;
  endtask

  task automatic set_iss(input int i, input logic [AW-1:0] a);
    bus.iss_valid[i]         = 1'b1;
    bus.iss_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rd(input int k);
    return bus.rdata[k*DW +: DW];
  endfunction

  function automatic logic [31:0] rb(input int k);
    return {31'b0, bus.rbusy[k]};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.raddr = '0;
    idle();

    // Reset while writes to r5 and an issue to r7 are pending.
    reset = 1'b1;
    set_wr(0, 5'd5, 32'hAAAA_0001);
    set_wr(1, 5'd5, 32'hAAAA_0002);
    set_iss(0, 5'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    set_rd(0, 5'd7); set_rd(1, 5'd5); set_rd(2, 5'd0); set_rd(3, 5'd1);
    #1;
    check("rst_rdata_r7", rd(0), 32'h0);
    check("rst_rdata_r5", rd(1), 32'h0);
    check("rst_rdata_r0", rd(2), 32'h0);
    check("rst_rbusy_r7", rb(0), 32'h0);
    check("rst_rbusy_r5", rb(1), 32'h0);

    // Single write with same-cycle bypass, then array read.
    @(negedge clk);
    set_wr(0, 5'd3, 32'hDEAD_BEEF);
    set_rd(0, 5'd3);
    #1;
    check("byp_r3", rd(0), 32'hDEAD_BEEF);
    check("byp_r3_busy", rb(0), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("arr_r3", rd(0), 32'hDEAD_BEEF);
    check("arr_r3_busy", rb(0), 32'h0);

    // Two ports write r9: port 1 wins in the bypass and the array.
    @(negedge clk);
    set_wr(0, 5'd9, 32'h11);
    set_wr(1, 5'd9, 32'h22);
    set_rd(1, 5'd9);
    #1;
    check("pri_byp_r9", rd(1), 32'h22);
    @(negedge clk);
    idle();
    #1;
    check("pri_arr_r9", rd(1), 32'h22);
    check("arr_r3_kept", rd(0), 32'hDEAD_BEEF);

    // Writes and issues to r0 have no effect.
    @(negedge clk);
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_iss(0, 5'd0);
    set_rd(2, 5'd0);
    #1;
    check("r0_byp", rd(2), 32'h0);
    check("r0_byp_busy", rb(2), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("r0_arr", rd(2), 32'h0);
    check("r0_arr_busy", rb(2), 32'h0);

    // Issue r4 at t, writeback r4 at t+3.
    @(negedge clk);
    set_iss(0, 5'd4);
    set_rd(3, 5'd4);
    #1;
    check("iss_r4_t0", rb(3), 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("iss_r4_t1", rb(3), 32'h1);
    @(negedge clk);
    #1;
    check("iss_r4_t2", rb(3), 32'h1);
    @(negedge clk);
    set_wr(1, 5'd4, 32'h0000_0044);
    #1;
    check("wb_r4_t3_busy", rb(3), 32'h0);
    check("wb_r4_t3_data", rd(3), 32'h0000_0044);
    @(negedge clk);
    idle();
    #1;
    check("wb_r4_t4_busy", rb(3), 32'h0);
    check("wb_r4_t4_data", rd(3), 32'h0000_0044);

    // Issue and writeback to r6 in the same cycle while r6 is busy: set wins.
    @(negedge clk);
    set_iss(1, 5'd6);
    set_rd(0, 5'd6);
    @(negedge clk);
    idle();
    #1;
    check("r6_busy_pre", rb(0), 32'h1);
    @(negedge clk);
    set_iss(1, 5'd6);
    set_wr(0, 5'd6, 32'h0000_0066);
    #1;
    check("r6_same_busy", rb(0), 32'h0);
    check("r6_same_data", rd(0), 32'h0000_0066);
    @(negedge clk);
    idle();
    #1;
    check("r6_next_busy", rb(0), 32'h1);
    check("r6_next_data", rd(0), 32'h0000_0066);

    // Duplicate issue to r8, then a writeback through port 0 clears it.
    @(negedge clk);
    set_iss(0, 5'd8);
    set_iss(1, 5'd8);
    set_rd(1, 5'd8);
    @(negedge clk);
    idle();
    #1;
    check("dup_r8_busy", rb(1), 32'h1);
    @(negedge clk);
    set_wr(0, 5'd8, 32'h0000_0088);
    @(negedge clk);
    idle();
    #1;
    check("r8_cleared", rb(1), 32'h0);
    check("r8_data", rd(1), 32'h0000_0088);
    check("r6_still_busy", rb(0), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
